// File: rtl/divider_seq.sv
// Multi-cycle restoring divider: one quotient bit per clock, unsigned or signed
// (truncating) operands, start/busy/done handshake and divide-by-zero flag.
module divider_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] dvd, dvs, rem, quot;
    logic [CNT_W-1:0] cnt;
    logic             qneg, rneg, dz;
    logic [WIDTH:0]   s, diff;
    logic             ge;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic sm);
        return (sm && (v < 0)) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic neg);
        return neg ? -mag : mag;
    endfunction

    // The borrow out of the WIDTH+1 bit subtraction is the "s < divisor" test.
    assign s    = {rem, dvd[WIDTH-1]};
    assign diff = s - {1'b0, dvs};
    assign ge   = ~diff[WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (b == '0) ? FIX : RUN;
            RUN:     if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quot     <= '0;
            cnt      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    qneg <= sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg <= sign_mode & a[WIDTH-1];
                    // On divide-by-zero the raw dividend is kept for the remainder.
                    dvd  <= (b == '0) ? a : magnitude(a, sign_mode);
                    dvs  <= magnitude(b, sign_mode);
                    rem  <= '0;
                    quot <= '0;
                    cnt  <= CNT_W'(WIDTH - 1);
                    dz   <= (b == '0);
                end
                RUN: begin
                    dvd  <= dvd << 1;
                    rem  <= ge ? diff[WIDTH-1:0] : s[WIDTH-1:0];
                    quot <= {quot[WIDTH-2:0], ge};
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (dz) begin
                        q <= '1;
                        r <= dvd;
                    end else begin
                        q <= apply_sign(quot, qneg);
                        r <= apply_sign(rem, rneg);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed 32-bit cases plus 1000 random
// 8-bit operations compared against a plain-arithmetic reference model.
module tb_divider_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start32, sm32, busy32, done32, dz32;
    logic [31:0] a32, b32, q32, r32;
    logic        start8, sm8, busy8, done8, dz8;
    logic [7:0]  a8, b8, q8, r8;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    divider_seq #(.WIDTH(32)) u_div32 (
        .clock(clock), .reset(reset), .start(start32), .sign_mode(sm32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .q(q32), .r(r32),
        .div_zero(dz32)
    );

    divider_seq #(.WIDTH(8)) u_div8 (
        .clock(clock), .reset(reset), .start(start8), .sign_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .q(q8), .r(r8),
        .div_zero(dz8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: interpret operands as w-bit numbers, divide with integer arithmetic.
    function automatic void ref_div(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                    input bit sm, output logic [31:0] qe,
                                    output logic [31:0] re, output bit dze);
        longint mask, av, bv, qq, rr;
        mask = (longint'(1) << w) - 1;
        av   = longint'({32'b0, ai}) & mask;
        bv   = longint'({32'b0, bi}) & mask;
        if (sm) begin
            if (av > (mask >> 1)) av = av - (mask + 1);
            if (bv > (mask >> 1)) bv = bv - (mask + 1);
        end
        if (bv == 0) begin
            qe  = mask[31:0];
            re  = ai & mask[31:0];
            dze = 1'b1;
        end else begin
            qq  = (av / bv) & mask;
            rr  = (av % bv) & mask;
            qe  = qq[31:0];
            re  = rr[31:0];
            dze = 1'b0;
        end
    endfunction

    task automatic run32(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input bit sm, input bit poke, input bit tail,
                         output logic [31:0] gq, output logic [31:0] gr);
        int n, bc, lat;
        logic [31:0] eq, er;
        bit edz;
        ref_div(32, ia, ib, sm, eq, er, edz);
        lat = (ib == 0) ? 1 : 33;
        @(negedge clock);
        a32 = ia; b32 = ib; sm32 = sm; start32 = 1'b1;
        @(posedge clock); #1;
        bc = int'(busy32);
        n  = 0;
        do begin
            @(negedge clock);
            start32 = poke && (n == 3);
            a32 = $urandom; b32 = $urandom; sm32 = ~sm;
            @(posedge clock); #1;
            n++;
            bc += int'(busy32);
        end while (!done32 && n < 100);
        start32 = 1'b0;
        check({tag, "_lat"},  n, lat);
        check({tag, "_busy"}, bc, lat);
        check({tag, "_q"},    q32, eq);
        check({tag, "_r"},    r32, er);
        check({tag, "_dz"},   dz32, edz);
        gq = q32; gr = r32;
        if (tail) begin
            @(posedge clock); #1;
            check({tag, "_done_pulse"}, done32, 1'b0);
            check({tag, "_q_hold"},     q32, eq);
        end
    endtask

    initial begin
        logic [31:0] gq, gr, eq, er;
        logic [7:0]  ta, tb;
        bit          tsm, edz;
        int          n, seen;

        reset = 1'b1;
        start32 = 0; sm32 = 0; a32 = 0; b32 = 0;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        #1;
        check("rst_busy", busy32, 1'b0);
        check("rst_done", done32, 1'b0);
        check("rst_q",    q32, 32'h0);
        check("rst_r",    r32, 32'h0);
        check("rst_dz",   dz32, 1'b0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;

        run32("u100_7", 32'd100, 32'd7, 1'b0, 1'b0, 1'b1, gq, gr);
        check("u100_7_q14", gq, 32'd14);
        check("u100_7_r2",  gr, 32'd2);
        run32("sm100_7", 32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, 1'b1, gq, gr);
        check("sm100_7_q", gq, 32'hFFFFFFF2);
        check("sm100_7_r", gr, 32'hFFFFFFFE);
        run32("s100_m7", 32'd100, 32'hFFFFFFF9, 1'b1, 1'b0, 1'b1, gq, gr);
        check("s100_m7_q", gq, 32'hFFFFFFF2);
        check("s100_m7_r", gr, 32'd2);
        run32("dz", 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, gq, gr);
        check("dz_q", gq, 32'hFFFFFFFF);
        check("dz_r", gr, 32'h1234);
        run32("after_dz", 32'd9, 32'd3, 1'b0, 1'b0, 1'b1, gq, gr);
        run32("s_dz", 32'hFFFFFF00, 32'h0, 1'b1, 1'b0, 1'b1, gq, gr);
        run32("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, gq, gr);
        check("ovf_q", gq, 32'h80000000);
        run32("umax_1", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b1, gq, gr);
        run32("small", 32'd5, 32'd9, 1'b0, 1'b0, 1'b1, gq, gr);
        run32("poke", 32'd1000, 32'd33, 1'b0, 1'b1, 1'b1, gq, gr);
        run32("b2b_1", 32'd77, 32'd5, 1'b0, 1'b0, 1'b0, gq, gr);
        run32("b2b_2", 32'hFFFFF000, 32'd12, 1'b1, 1'b0, 1'b1, gq, gr);
        for (int i = 0; i < 12; i++)
            run32("rnd32", $urandom, $urandom >> (i * 2), 1'($urandom), 1'b0, 1'b0, gq, gr);

        // Abort mid-run: outputs must clear without a clock edge and no done follows.
        @(negedge clock);
        a32 = 32'd1000; b32 = 32'd3; sm32 = 1'b0; start32 = 1'b1;
        @(posedge clock);
        @(negedge clock); start32 = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", busy32, 1'b0);
        check("mid_rst_done", done32, 1'b0);
        check("mid_rst_q",    q32, 32'h0);
        check("mid_rst_r",    r32, 32'h0);
        check("mid_rst_dz",   dz32, 1'b0);
        @(negedge clock); reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done32 || busy32) seen++;
        end
        check("mid_rst_no_done", seen, 0);
        run32("post_rst", 32'd50, 32'd5, 1'b0, 1'b0, 1'b1, gq, gr);
        check("post_rst_q10", gq, 32'd10);

        for (int i = 0; i < 1000; i++) begin
            ta  = 8'($urandom);
            tb  = (i % 64 == 0) ? 8'h0 : 8'($urandom);
            tsm = 1'($urandom);
            ref_div(8, {24'b0, ta}, {24'b0, tb}, tsm, eq, er, edz);
            @(negedge clock);
            a8 = ta; b8 = tb; sm8 = tsm; start8 = 1'b1;
            @(posedge clock);
            @(negedge clock);
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            n = 0;
            do begin
                @(posedge clock); #1;
                n++;
            end while (!done8 && n < 40);
            check("r8_lat", n, (tb == 0) ? 1 : 9);
            check("r8_q",   q8, eq[7:0]);
            check("r8_r",   r8, er[7:0]);
            check("r8_dz",  dz8, edz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Parametrised multi-cycle restoring divider. It produces one quotient bit per clock and supports unsigned and signed (two's-complement, truncating) operation.
- It adds a start/busy/done handshake, divide-by-zero handling and asynchronous reset.
- It is the general-purpose divide unit for the datapath and is used wherever a single-cycle divider is too costly.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, do not override)

Ports:
clock     input   1      system clock, rising edge
reset     input   1      asynchronous, active-high reset
start     input   1      request; sampled only in IDLE
sign_mode input   1      0 = unsigned, 1 = signed; sampled with start
a         input   WIDTH  dividend; sampled with start
b         input   WIDTH  divisor; sampled with start
busy      output  1      high while an operation is in progress (RUN or FIX)
done      output  1      one-cycle pulse; q/r/div_zero valid from this cycle
q         output  WIDTH  quotient
r         output  WIDTH  remainder
div_zero  output  1      set with done when b was 0; held until next done

Behaviour:
- Clock and reset: one clock `clock`; reset `reset` is asynchronous and active-high.
- Reset, effective immediately and regardless of state:
  - state = IDLE;
  - busy = 0, done = 0, q = 0, r = 0, div_zero = 0;
  - internal registers cleared.
- Reset mid-operation aborts the operation; no done is produced.
- States are IDLE, RUN and FIX.
- IDLE:
  - On start = 1 at edge k, latch sign_mode.
  - Latch |a| and |b| (magnitudes when sign_mode = 1, raw values otherwise).
  - Latch sign flags: qneg = a_msb XOR b_msb, rneg = a_msb (both forced 0 in unsigned mode).
  - Clear the partial remainder; set counter = WIDTH-1.
  - If b == 0: go to FIX with the dz flag set. Otherwise go to RUN.
  - busy = 1 from edge k onward.
- RUN, one edge per bit, MSB first:
  - s = {rem[WIDTH-1:0], dividend[cnt]}, computed WIDTH+1 bits wide so no overflow is possible.
  - If s >= divisor: rem = s - divisor and qbit = 1. Else rem = s and qbit = 0.
  - When the counter reaches 0, that edge processes bit 0 and moves to FIX. Otherwise decrement the counter.
  - This takes exactly WIDTH edges (k+1 .. k+WIDTH).
- FIX, one edge:
  - Register q = qneg ? -qmag : qmag and r = rneg ? -rmag : rmag.
  - Pulse done = 1; busy = 0; go to IDLE.
- Divide-by-zero result: q = all ones, r = a (the original signed or unsigned value), div_zero = 1.
- Latency:
  - Nonzero divisor: done is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 edges after start is sampled.
  - Divide-by-zero: edge k+1 (2 edges).
- done is high for exactly one cycle. q, r and div_zero hold until the next done or reset. div_zero is cleared on a done with a nonzero divisor.
- start while busy is ignored; inputs a, b and sign_mode may change freely after being sampled.
- start may be asserted in the same cycle done is high. The FSM is in IDLE by then, so the new operation starts back-to-back.
- Signed arithmetic rules:
  - Quotient truncates toward zero; the remainder takes the dividend's sign; a = q*b + r always holds.
  - Overflow case MIN / -1 gives q = MIN, r = 0 with div_zero = 0. This falls out of the magnitude arithmetic; no special case is needed.
- All outputs are registered; no combinational path from the inputs to the outputs.

Test Plan:
- Unsigned, WIDTH=32: a=100, b=7, sign_mode=0, start 1 cycle -> busy for 33 cycles, done 34 edges after start; q=14, r=2, div_zero=0.
- Signed: a=-100 (0xFFFFFF9C), b=7, sign_mode=1 -> q=-14 (0xFFFFFFF2), r=-2 (0xFFFFFFFE). Also a=100, b=-7 -> q=-14, r=2.
- Divide-by-zero: a=0x1234, b=0 -> done on the 2nd edge; q=0xFFFFFFFF, r=0x1234, div_zero=1. Next op a=9, b=3 -> q=3, r=0, div_zero=0.
- Signed overflow and corner cases:
  - a=0x80000000, b=0xFFFFFFFF, sign_mode=1 -> q=0x80000000, r=0.
  - Unsigned a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0.
  - a=5, b=9 -> q=0, r=5.
- Handshake:
  - start pulsed again while busy with different operands -> ignored, first result correct.
  - start asserted in the done cycle -> second result follows exactly WIDTH+2 edges later.
- Reset mid-RUN (cycle 10) -> all outputs 0 immediately without waiting for a clock edge; no done pulse.
  - Afterwards, a=50, b=5 -> q=10, r=0.
  - Repeat the 1000-vector random signed/unsigned comparison against a software model with WIDTH=8.
